// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressed memory: size encodings, FSM states and the size decoder.
package mem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   // Byte count of an access; the illegal encoding reports 0 bytes.
   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_B:    size_bytes = 4'd1;
         SZ_H:    size_bytes = 4'd2;
         SZ_W:    size_bytes = 4'd4;
         default: size_bytes = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/byte_ram_bank.sv
// One byte lane of the memory: ROWS x 8-bit simple dual-port RAM with a registered read.
module byte_ram_bank
   import mem_pkg::*;
#(
   parameter int ROWS = 344,
   parameter int RW   = $clog2(ROWS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [RW-1:0] wa,
   input  logic [7:0]    wd,
   input  logic          re,
   input  logic [RW-1:0] ra,
   output logic [7:0]    rd
);

   logic [7:0] mem [ROWS];

   // Read returns the old contents on a same-row collision; the parent applies write-first bypass.
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      if (re) rd <= mem[ra];
   end

endmodule

// File: rtl/byte_ram.sv
// Byte-addressed data memory with unaligned B/H/W accesses, write-first bypass and a post-reset clear sweep.
// BANKS (DATA_W/8) is assumed to be a power of two of at least 2.
module byte_ram
   import mem_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH_BYTES = 1376,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [1:0]        rd_size,
   input  logic              rd_signed,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_err,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [1:0]        wr_size,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_err,
   output logic              ready
);

   localparam int BANKS = DATA_W / 8;
   localparam int ROWS  = DEPTH_BYTES / BANKS;
   localparam int RW    = $clog2(ROWS);
   localparam int OFF_W = $clog2(BANKS);
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH_BYTES);

   state_t          state, state_next;
   logic [RW-1:0]   cnt;

   logic [ADDR_W:0] rd_end, wr_end;
   logic            rd_legal, wr_legal, rd_acc, rd_ok, wr_ok;
   logic [OFF_W-1:0] rd_off, wr_off;
   logic [RW-1:0]   rd_row, wr_row;

   logic [OFF_W-1:0] rd_lane [BANKS];
   logic [OFF_W-1:0] wr_lane [BANKS];
   logic [RW-1:0]   rd_bank_row [BANKS];
   logic [RW-1:0]   wr_bank_row [BANKS];
   logic [7:0]      wr_bank_byte [BANKS];
   logic [BANKS-1:0] rd_touch, wr_touch, bypass;

   logic [BANKS-1:0] bank_we, bank_re;
   logic [RW-1:0]   bank_wa [BANKS];
   logic [7:0]      bank_wd [BANKS];
   logic [7:0]      bank_q  [BANKS];

   logic            rd_zero, rd_signed_q;
   logic [1:0]      rd_size_q;
   logic [OFF_W-1:0] rd_off_q;
   logic [BANKS-1:0] byp_q;
   logic [7:0]      byp_data_q [BANKS];

   logic [OFF_W-1:0] idx;
   logic [DATA_W-1:0] word;
   logic            sgn;

   // The sum is one bit wider than the address so a request near the top of the address space cannot wrap.
   always_comb begin
      ready    = (state == ST_IDLE);
      rd_end   = {1'b0, rd_addr} + (ADDR_W+1)'(size_bytes(rd_size));
      wr_end   = {1'b0, wr_addr} + (ADDR_W+1)'(size_bytes(wr_size));
      rd_legal = (rd_size != SZ_X) && (rd_end <= DEPTH_EXT);
      wr_legal = (wr_size != SZ_X) && (wr_end <= DEPTH_EXT);
      rd_acc   = rd_en && ready;
      rd_ok    = rd_acc && rd_legal;
      wr_ok    = wr_en && ready && wr_legal;
      rd_off   = rd_addr[OFF_W-1:0];
      wr_off   = wr_addr[OFF_W-1:0];
      rd_row   = rd_addr[OFF_W +: RW];
      wr_row   = wr_addr[OFF_W +: RW];
      for (int b = 0; b < BANKS; b++) begin
         rd_lane[b]      = OFF_W'(b) - rd_off;
         wr_lane[b]      = OFF_W'(b) - wr_off;
         rd_touch[b]     = int'(rd_lane[b]) < int'(size_bytes(rd_size));
         wr_touch[b]     = int'(wr_lane[b]) < int'(size_bytes(wr_size));
         rd_bank_row[b]  = rd_row + RW'(OFF_W'(b) < rd_off);
         wr_bank_row[b]  = wr_row + RW'(OFF_W'(b) < wr_off);
         wr_bank_byte[b] = wr_data[8*wr_lane[b] +: 8];
         bypass[b]       = rd_ok && rd_touch[b] && wr_ok && wr_touch[b]
                           && (rd_bank_row[b] == wr_bank_row[b]);
         bank_we[b]      = (state == ST_CLEAR) || (wr_ok && wr_touch[b]);
         bank_wa[b]      = (state == ST_CLEAR) ? cnt : wr_bank_row[b];
         bank_wd[b]      = (state == ST_CLEAR) ? 8'h00 : wr_bank_byte[b];
         bank_re[b]      = rd_ok && rd_touch[b];
      end
   end

   for (genvar g = 0; g < BANKS; g++) begin : g_bank
      byte_ram_bank #(.ROWS(ROWS), .RW(RW)) u_bank (
         .clk (clk),
         .we  (bank_we[g]),
         .wa  (bank_wa[g]),
         .wd  (bank_wd[g]),
         .re  (bank_re[g]),
         .ra  (rd_bank_row[g]),
         .rd  (bank_q[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (state == ST_CLEAR) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_CLEAR: if (cnt == RW'(ROWS-1)) state_next = ST_IDLE;
         ST_IDLE:  state_next = ST_IDLE;
         default:  state_next = ST_CLEAR;
      endcase
   end

   // Read context is captured only on an accepted read, so rd_data holds between reads.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_valid    <= 1'b0;
         rd_err      <= 1'b0;
         wr_err      <= 1'b0;
         rd_zero     <= 1'b1;
         rd_off_q    <= '0;
         rd_size_q   <= SZ_W;
         rd_signed_q <= 1'b0;
         byp_q       <= '0;
      end else begin
         rd_valid <= rd_acc;
         wr_err   <= wr_en && ready && !wr_legal;
         if (rd_acc) begin
            rd_err      <= !rd_legal;
            rd_zero     <= !rd_legal;
            rd_off_q    <= rd_off;
            rd_size_q   <= rd_size;
            rd_signed_q <= rd_signed;
            byp_q       <= bypass;
            byp_data_q  <= wr_bank_byte;
         end
      end
   end

   always_comb begin
      idx  = '0;
      word = '0;
      for (int i = 0; i < BANKS; i++) begin
         idx = rd_off_q + OFF_W'(i);
         word[8*i +: 8] = byp_q[idx] ? byp_data_q[idx] : bank_q[idx];
      end
      sgn = 1'b0;
      case (rd_size_q)
         SZ_B: begin
            sgn     = rd_signed_q && word[7];
            rd_data = {{(DATA_W-8){sgn}}, word[7:0]};
         end
         SZ_H: begin
            sgn     = rd_signed_q && word[15];
            rd_data = {{(DATA_W-16){sgn}}, word[15:0]};
         end
         default: rd_data = word;
      endcase
      if (rd_zero) rd_data = '0;
   end

endmodule
